// File: rtl/wb_regfile.sv
// wb_regfile: RISC-V write-back select plus 32x32 architectural register file.
// Two combinational read ports with write-first bypass; commit counter for debug.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] MEM_WB_Read_Data,
   input  logic [DATA_W-1:0] MEM_WB_ALUout,
   input  logic [DATA_W-1:0] MEM_WB_PC4,
   input  logic [4:0]        MEM_WB_RD,
   input  logic              MEM_WB_RegWrite,
   input  logic [2:0]        MEM_WB_WDSel,
   input  logic [4:0]        rs1_addr,
   input  logic [4:0]        rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data,
   output logic [DATA_W-1:0] WB_WD,
   output logic              WB_WE,
   output logic [CNT_W-1:0]  wb_count
);

   logic [DATA_W-1:0] regs_r [0:31];
   logic [DATA_W-1:0] wb_wd_s;
   logic              sel_ok_s;
   logic              wb_we_s;
   logic [DATA_W-1:0] rs1_data_s;
   logic [DATA_W-1:0] rs2_data_s;
   logic [CNT_W-1:0]  wb_count_r;

   // Index 0 reads as zero; a same-cycle commit to the index wins over the array.
   function automatic logic [DATA_W-1:0] read_sel(
      input logic [4:0]        addr,
      input logic [DATA_W-1:0] arr_val,
      input logic              we,
      input logic [4:0]        rd,
      input logic [DATA_W-1:0] wd
   );
      logic [DATA_W-1:0] val;
      if (addr == 5'd0) begin
         val = {DATA_W{1'b0}};
      end else if (we && (addr == rd)) begin
         val = wd;
      end else begin
         val = arr_val;
      end
      return val;
   endfunction

   // Write-back data select; unused encodings yield zero and block the commit.
   always_comb begin
      wb_wd_s  = {DATA_W{1'b0}};
      sel_ok_s = 1'b0;
      case (MEM_WB_WDSel)
         3'd0: begin
            wb_wd_s  = MEM_WB_ALUout;
            sel_ok_s = 1'b1;
         end
         3'd1: begin
            wb_wd_s  = MEM_WB_Read_Data;
            sel_ok_s = 1'b1;
         end
         3'd2: begin
            wb_wd_s  = MEM_WB_PC4;
            sel_ok_s = 1'b1;
         end
         default: begin
            wb_wd_s  = {DATA_W{1'b0}};
            sel_ok_s = 1'b0;
         end
      endcase
   end

   // Effective write enable, gated by reset so nothing commits or bypasses in reset.
   always_comb begin
      wb_we_s = rst & MEM_WB_RegWrite & (MEM_WB_RD != 5'd0) & sel_ok_s;
   end

   // Decode-stage read ports.
   always_comb begin
      rs1_data_s = read_sel(rs1_addr, regs_r[rs1_addr], wb_we_s, MEM_WB_RD, wb_wd_s);
      rs2_data_s = read_sel(rs2_addr, regs_r[rs2_addr], wb_we_s, MEM_WB_RD, wb_wd_s);
   end

   // Register array; entry 0 is never written because wb_we_s excludes rd 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_we_s) begin
         regs_r[MEM_WB_RD] <= wb_wd_s;
      end
   end

   // Commit counter, wraps naturally at its width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_count_r <= {CNT_W{1'b0}};
      end else if (wb_we_s) begin
         wb_count_r <= wb_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign rs1_data = rs1_data_s;
   assign rs2_data = rs2_data_s;
   assign WB_WD    = wb_wd_s;
   assign WB_WE    = wb_we_s;
   assign wb_count = wb_count_r;

   wb_regfile_chk #(.DATA_W(DATA_W)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .rd       (MEM_WB_RD),
      .we       (wb_we_s),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data_s),
      .rs2_data (rs2_data_s)
   );

endmodule

// wb_regfile_chk: structural invariants of the register file, sampled mid-cycle.
module wb_regfile_chk #(
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   input logic [4:0]        rd,
   input logic              we,
   input logic [4:0]        rs1_addr,
   input logic [4:0]        rs2_addr,
   input logic [DATA_W-1:0] rs1_data,
   input logic [DATA_W-1:0] rs2_data
);

   // Check invariants away from the active edge, once inputs have settled.
   always @(negedge clk) begin
      a_no_x0_write : assert (!(we && (rd == 5'd0)));
      a_no_we_rst   : assert (rst || !we);
      a_rs1_x0      : assert ((rs1_addr != 5'd0) || (rs1_data == {DATA_W{1'b0}}));
      a_rs2_x0      : assert ((rs2_addr != 5'd0) || (rs2_data == {DATA_W{1'b0}}));
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed stimulus with a queue-based scoreboard; a negedge monitor
// pops expected values and compares them against the two DUT instances.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [31:0] rdata, aluout, pc4;
   logic [4:0]  rd, a1, a2;
   logic        regwrite;
   logic [2:0]  wdsel;
   logic [31:0] rs1_data, rs2_data, wb_wd;
   logic        wb_we;
   logic [31:0] wb_count;
   logic [31:0] rs1_data4, rs2_data4, wb_wd4;
   logic        wb_we4;
   logic [3:0]  wb_count4;

   typedef struct {
      string       nm;
      int          sel;
      logic [31:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   nw    = 0;

   localparam int S_RS1 = 0, S_RS2 = 1, S_WD = 2, S_WE = 3, S_CNT = 4, S_CNT4 = 5;

   wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .MEM_WB_Read_Data(rdata), .MEM_WB_ALUout(aluout), .MEM_WB_PC4(pc4),
      .MEM_WB_RD(rd), .MEM_WB_RegWrite(regwrite), .MEM_WB_WDSel(wdsel),
      .rs1_addr(a1), .rs2_addr(a2),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .WB_WD(wb_wd), .WB_WE(wb_we), .wb_count(wb_count)
   );

   wb_regfile #(.DATA_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .MEM_WB_Read_Data(rdata), .MEM_WB_ALUout(aluout), .MEM_WB_PC4(pc4),
      .MEM_WB_RD(rd), .MEM_WB_RegWrite(regwrite), .MEM_WB_WDSel(wdsel),
      .rs1_addr(a1), .rs2_addr(a2),
      .rs1_data(rs1_data4), .rs2_data(rs2_data4),
      .WB_WD(wb_wd4), .WB_WE(wb_we4), .wb_count(wb_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every queued expectation is compared on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] act;
         e = sb.pop_front();
         case (e.sel)
            S_RS1:   act = rs1_data;
            S_RS2:   act = rs2_data;
            S_WD:    act = wb_wd;
            S_WE:    act = {31'd0, wb_we};
            S_CNT:   act = wb_count;
            S_CNT4:  act = {28'd0, wb_count4};
            default: act = 32'hxxxx_xxxx;
         endcase
         n_cmp++;
         if (act !== e.v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, act, e.v);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] d, input logic [2:0] s,
                        input logic [31:0] alu, input logic [31:0] rdv, input logic [31:0] pc,
                        input logic [4:0] r1, input logic [4:0] r2);
      regwrite = we; rd = d; wdsel = s;
      aluout = alu; rdata = rdv; pc4 = pc;
      a1 = r1; a2 = r2;
   endtask

   task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
      exp_t e;
      e.nm = nm; e.sel = sel; e.v = v;
      sb.push_back(e);
   endtask

   task automatic expect_cnt(input string nm);
      expect_v({nm, "_cnt"}, S_CNT, nw);
      expect_v({nm, "_cnt4"}, S_CNT4, nw % 16);
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      step();
      expect_v("rst_rs1", S_RS1, 32'd0);
      expect_cnt("rst");
      step();
      rst = 1'b1;
      step();

      // Reset behaviour after a committed write
      drive(1'b1, 5'd5, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd5, 5'd0);
      step(); nw = 1;
      drive(1'b0, 5'd5, 3'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
      expect_v("x5_written", S_RS1, 32'hDEAD_BEEF);
      expect_cnt("x5_written");
      step();
      rst = 1'b0; nw = 0;
      drive(1'b1, 5'd5, 3'd0, 32'h77, 32'd0, 32'd0, 5'd5, 5'd5);
      expect_v("rst_mid_rs1", S_RS1, 32'd0);
      expect_v("rst_mid_rs2", S_RS2, 32'd0);
      expect_v("rst_mid_we", S_WE, 32'd0);
      expect_v("rst_mid_wd", S_WD, 32'h77);
      expect_cnt("rst_mid");
      step();
      drive(1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
      rst = 1'b1;
      step();
      expect_v("rst_rel_rs1", S_RS1, 32'd0);
      expect_cnt("rst_rel");
      step();

      // Independence: x1..x31 = 0x100+i, read pairs (i, 31-i)
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 3'd0, 32'h100 + 32'(i), 32'd0, 32'd0, 5'd0, 5'd0);
         step();
         nw++;
      end
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
         expect_v("pair_rs1", S_RS1, (i == 0) ? 32'd0 : 32'h100 + 32'(i));
         expect_v("pair_rs2", S_RS2, (i == 31) ? 32'd0 : 32'h100 + 32'(31 - i));
         step();
      end
      expect_cnt("indep");
      step();

      // Select mux on rd=7
      for (int s = 0; s < 3; s++) begin
         logic [31:0] ev;
         ev = (s == 0) ? 32'h11 : (s == 1) ? 32'h22 : 32'h33;
         drive(1'b1, 5'd7, 3'(s), 32'h11, 32'h22, 32'h33, 5'd7, 5'd0);
         expect_v("mux_wd", S_WD, ev);
         expect_v("mux_we", S_WE, 32'd1);
         expect_v("mux_bypass", S_RS1, ev);
         step(); nw++;
         drive(1'b0, 5'd7, 3'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
         expect_v("mux_arr", S_RS1, ev);
         expect_cnt("mux");
         step();
      end
      drive(1'b1, 5'd7, 3'd5, 32'h11, 32'h22, 32'h33, 5'd7, 5'd0);
      expect_v("sel5_we", S_WE, 32'd0);
      expect_v("sel5_wd", S_WD, 32'd0);
      expect_v("sel5_rs1", S_RS1, 32'h33);
      step();
      drive(1'b0, 5'd7, 3'd0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
      expect_v("sel5_arr", S_RS1, 32'h33);
      expect_cnt("sel5");
      step();

      // x0 protection
      drive(1'b1, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0);
      expect_v("x0_we", S_WE, 32'd0);
      expect_v("x0_rs1", S_RS1, 32'd0);
      expect_v("x0_rs2", S_RS2, 32'd0);
      step();
      drive(1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      expect_v("x0_after", S_RS1, 32'd0);
      expect_cnt("x0");
      step();

      // Dual-port bypass on x10
      drive(1'b1, 5'd10, 3'd0, 32'h1234, 32'd0, 32'd0, 5'd10, 5'd10);
      expect_v("byp_rs1", S_RS1, 32'h1234);
      expect_v("byp_rs2", S_RS2, 32'h1234);
      step(); nw++;
      drive(1'b0, 5'd10, 3'd0, 32'd0, 32'd0, 32'd0, 5'd10, 5'd10);
      expect_v("byp_arr_rs1", S_RS1, 32'h1234);
      expect_v("byp_arr_rs2", S_RS2, 32'h1234);
      expect_cnt("byp");
      step();

      // Counter wrap after fresh reset: 17 back-to-back writes to x3
      rst = 1'b0; nw = 0;
      step();
      rst = 1'b1;
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 5'd3, 3'd0, 32'hA000 + 32'(k), 32'd0, 32'd0, 5'd0, 5'd0);
         step();
         nw++;
      end
      drive(1'b0, 5'd3, 3'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0);
      expect_v("wrap_x3", S_RS1, 32'hA010);
      expect_v("wrap_cnt4", S_CNT4, 32'd1);
      expect_v("wrap_cnt", S_CNT, 32'd17);
      step();
      step();

      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
